// File: rtl/normalizer.sv
// Iterative normalizer: shifts the operand one bit per cycle toward the target end
// and reports the shift count. Optional `NORMALIZER_LIMIT_EN adds a shift-count limit.
module normalizer #(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_direction,
  input  logic [N-1:0] i_value,
`ifdef NORMALIZER_LIMIT_EN
  input  logic [N-1:0] i_limit,
  output logic         o_limited,
`endif
  output logic         o_busy,
  output logic         o_finished,
  output logic [N-1:0] o_value,
  output logic [N-1:0] o_count,
  output logic         o_zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]   state;
  logic         direction;
  logic         target_hit;
  logic [N-1:0] shifted;

  // Left normalizes toward the MSB, right toward the LSB; vacated bits fill with zero.
  assign target_hit = direction ? o_value[N-1] : o_value[0];
  assign shifted    = direction ? {o_value[N-2:0], 1'b0} : {1'b0, o_value[N-1:1]};

  assign o_busy     = (state != IDLE);
  assign o_finished = (state == DONE);

`ifdef NORMALIZER_LIMIT_EN
  logic [N-1:0] limit;
  logic         limit_hit;

  assign limit_hit = (o_count == limit);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      limit     <= '0;
      o_limited <= 1'b0;
    end else if (state == IDLE && i_start) begin
      limit     <= i_limit;
      o_limited <= 1'b0;
    end else if (state == SHIFT && !o_zero && !target_hit && limit_hit) begin
      o_limited <= 1'b1;
    end
  end
`else
  logic limit_hit;

  assign limit_hit = 1'b0;
`endif

  // Outputs are the working registers, so they track each shift and hold after DONE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      direction <= 1'b0;
      o_value   <= '0;
      o_count   <= '0;
      o_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            direction <= i_direction;
            o_value   <= i_value;
            o_count   <= '0;
            o_zero    <= (i_value == '0);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (o_zero || target_hit || limit_hit) begin
            state <= DONE;
          end else begin
            o_value <= shifted;
            o_count <= o_count + N'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_normalizer.sv
// Self-checking bench for normalizer (N=8): directed steps with a scoreboard of
// expected results popped when o_finished pulses.
module tb_normalizer;

  localparam int N = 8;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic         i_direction;
  logic [N-1:0] i_value;
  logic         o_busy;
  logic         o_finished;
  logic [N-1:0] o_value;
  logic [N-1:0] o_count;
  logic         o_zero;
`ifdef NORMALIZER_LIMIT_EN
  logic [N-1:0] i_limit;
  logic         o_limited;
`endif

  typedef struct {
    logic [N-1:0] value;
    logic [N-1:0] count;
    logic         zero;
    int           latency;
    logic         limited;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic seen_finish;

  normalizer #(.N(N)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_direction (i_direction),
    .i_value     (i_value),
`ifdef NORMALIZER_LIMIT_EN
    .i_limit     (i_limit),
    .o_limited   (o_limited),
`endif
    .o_busy      (o_busy),
    .o_finished  (o_finished),
    .o_value     (o_value),
    .o_count     (o_count),
    .o_zero      (o_zero)
  );

  always #5 i_clock = ~i_clock;

  task tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] value, input logic [N-1:0] count,
                          input logic zero, input int latency, input logic limited);
    exp_t e;
    e.value   = value;
    e.count   = count;
    e.zero    = zero;
    e.latency = latency;
    e.limited = limited;
    sb.push_back(e);
  endtask

  // Drives one accept edge and records the hand-derived expectation; the operand
  // and direction are scrambled afterwards to prove they are not re-sampled.
  task automatic applyStimulus(input logic [N-1:0] value, input logic dir,
                               input logic [N-1:0] exp_value, input logic [N-1:0] exp_count,
                               input logic exp_zero, input int exp_latency,
                               input logic exp_limited, input logic hold_start);
    i_start     = 1'b1;
    i_value     = value;
    i_direction = dir;
    push_exp(exp_value, exp_count, exp_zero, exp_latency, exp_limited);
    tick;
    if (!hold_start) i_start = 1'b0;
    i_value     = ~value;
    i_direction = ~dir;
  endtask

  // Waits (bounded) for o_finished, pops the oldest expectation and compares,
  // then checks the pulse is one cycle wide and the block returns to idle.
  task automatic checkOutput(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (!o_finished && lat < 40) begin
      tick;
      lat++;
    end
    check({tag, "_finished_seen"}, o_finished, 1'b1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_value"},   o_value, e.value);
    check({tag, "_count"},   o_count, e.count);
    check({tag, "_zero"},    o_zero, e.zero);
    check({tag, "_latency"}, lat, e.latency);
    check({tag, "_busy_in_done"}, o_busy, 1'b1);
`ifdef NORMALIZER_LIMIT_EN
    check({tag, "_limited"}, o_limited, e.limited);
`endif
    tick;
    check({tag, "_pulse_width"}, o_finished, 1'b0);
    check({tag, "_idle_after"},  o_busy, 1'b0);
    check({tag, "_value_hold"},  o_value, e.value);
  endtask

  initial begin
    i_reset     = 1'b1;
    i_start     = 1'b0;
    i_direction = 1'b0;
    i_value     = '0;
`ifdef NORMALIZER_LIMIT_EN
    i_limit     = '1;
`endif
    tick;
    tick;
    check("reset_value",    o_value, 8'h00);
    check("reset_count",    o_count, 8'h00);
    check("reset_zero",     o_zero, 1'b0);
    check("reset_busy",     o_busy, 1'b0);
    check("reset_finished", o_finished, 1'b0);
`ifdef NORMALIZER_LIMIT_EN
    check("reset_limited",  o_limited, 1'b0);
`endif
    i_reset = 1'b0;
    tick;

    $display("[TB] basic left/right normalization");
    applyStimulus(8'h13, 1'b1, 8'h98, 8'd3, 1'b0, 4, 1'b0, 1'b0);
    checkOutput("left_13");
    applyStimulus(8'h28, 1'b0, 8'h05, 8'd3, 1'b0, 4, 1'b0, 1'b0);
    checkOutput("right_28");
    applyStimulus(8'h80, 1'b1, 8'h80, 8'd0, 1'b0, 1, 1'b0, 1'b0);
    checkOutput("left_80");
    applyStimulus(8'h80, 1'b0, 8'h01, 8'd7, 1'b0, 8, 1'b0, 1'b0);
    checkOutput("right_80");
    applyStimulus(8'h01, 1'b0, 8'h01, 8'd0, 1'b0, 1, 1'b0, 1'b0);
    checkOutput("right_01");

    $display("[TB] zero operand");
    applyStimulus(8'h00, 1'b1, 8'h00, 8'd0, 1'b1, 1, 1'b0, 1'b0);
    checkOutput("zero_left");
    applyStimulus(8'h00, 1'b0, 8'h00, 8'd0, 1'b1, 1, 1'b0, 1'b0);
    checkOutput("zero_right");

    $display("[TB] held start, back-to-back ops");
    applyStimulus(8'h01, 1'b1, 8'h80, 8'd7, 1'b0, 8, 1'b0, 1'b1);
    i_value     = 8'h40;
    i_direction = 1'b1;
    push_exp(8'h80, 8'd1, 1'b0, 2, 1'b0);
    checkOutput("held_first");
    tick;
    check("held_second_accept", o_busy, 1'b1);
    i_start     = 1'b0;
    i_value     = 8'hFF;
    i_direction = 1'b0;
    checkOutput("held_second");

    $display("[TB] reset mid-operation");
    i_start     = 1'b1;
    i_value     = 8'h01;
    i_direction = 1'b1;
    tick;
    i_start = 1'b0;
    tick;
    i_reset = 1'b1;
    tick;
    check("midreset_busy",     o_busy, 1'b0);
    check("midreset_value",    o_value, 8'h00);
    check("midreset_count",    o_count, 8'h00);
    check("midreset_finished", o_finished, 1'b0);
    i_start = 1'b1;
    tick;
    check("reset_beats_start", o_busy, 1'b0);
    i_start = 1'b0;
    i_reset = 1'b0;
    seen_finish = 1'b0;
    repeat (12) begin
      tick;
      if (o_finished) seen_finish = 1'b1;
    end
    check("midreset_no_finish", seen_finish, 1'b0);

`ifdef NORMALIZER_LIMIT_EN
    $display("[TB] shift-count limit");
    i_limit = 8'd2;
    applyStimulus(8'h01, 1'b1, 8'h04, 8'd2, 1'b0, 3, 1'b1, 1'b0);
    checkOutput("limit_2");
    i_limit = 8'd0;
    applyStimulus(8'h01, 1'b1, 8'h01, 8'd0, 1'b0, 1, 1'b1, 1'b0);
    checkOutput("limit_0");
    i_limit = 8'd5;
    applyStimulus(8'h13, 1'b1, 8'h98, 8'd3, 1'b0, 4, 1'b0, 1'b0);
    checkOutput("limit_not_reached");
    i_limit = '1;
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
